// File: rtl/fetch_stage_if.sv
// Instruction-memory handshake between the fetch stage and the memory.
// One request is outstanding at a time: a request is accepted when
// imem_req && imem_ready, and its word comes back on imem_rvalid/imem_rdata.
interface fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, and drives a
// single-outstanding-request instruction-memory handshake. It honours the
// hazard unit's pc_freeze / IF_ID_flush and the EX-stage redirect.
// Optional build macro FETCH_PERF_CNT_EN adds bubble and drop counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pc_freeze,
  input  logic        IF_ID_flush,
  input  logic        Ex_jump_or_branch,
  input  logic [31:0] Ex_target_pc,
  fetch_stage_if.master imem,
  output logic [31:0] IF_ID_pc,
  output logic [31:0] IF_ID_inst,
  output logic        IF_ID_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_bubble_cnt,
  output logic [31:0] perf_drop_cnt
`endif
);

  // ISSUE: nothing outstanding; WAIT: outstanding, data wanted;
  // DROP: outstanding, data stale because a redirect overtook it.
  typedef enum logic [1:0] {ISSUE, WAIT, DROP} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inflight_pc;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  logic redirect;
  logic rsp_wait;
  logic rsp_drop;
  logic accept;
  logic bubble_load;

  assign redirect = Ex_jump_or_branch;
  assign rsp_wait = (state == WAIT) && imem.imem_rvalid;
  assign rsp_drop = ((state == DROP) && imem.imem_rvalid) || (rsp_wait && redirect);

  // A new request may go out on the very cycle the previous word returns,
  // which keeps a zero-wait memory at one instruction per cycle.
  assign imem.imem_req  = !pc_freeze && !redirect && ((state == ISSUE) || rsp_wait);
  assign imem.imem_addr = pc;
  assign accept         = imem.imem_req && imem.imem_ready;

  assign bubble_load = redirect || IF_ID_flush ||
                       (!pc_freeze && !hold_valid && !rsp_wait);

  // PC, request state machine and the hold buffer for words returned while frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      state       <= ISSUE;
      inflight_pc <= 32'h0;
      hold_valid  <= 1'b0;
      hold_pc     <= 32'h0;
      hold_inst   <= NOP_INST;
    end else if (redirect) begin
      pc         <= Ex_target_pc;
      hold_valid <= 1'b0;
      // A DROP whose stale word arrives now is finished; otherwise it keeps waiting.
      case (state)
        WAIT:    state <= imem.imem_rvalid ? ISSUE : DROP;
        DROP:    state <= imem.imem_rvalid ? ISSUE : DROP;
        default: state <= ISSUE;
      endcase
    end else begin
      if (accept) begin
        pc          <= pc + 32'd4;
        inflight_pc <= pc;
        state       <= WAIT;
      end else if (imem.imem_rvalid && (state != ISSUE)) begin
        state <= ISSUE;
      end
      if (rsp_wait && pc_freeze) begin
        hold_valid <= 1'b1;
        hold_pc    <= inflight_pc;
        hold_inst  <= imem.imem_rdata;
      end else if (hold_valid && !pc_freeze && !IF_ID_flush) begin
        hold_valid <= 1'b0;
      end
    end
  end

  // IF/ID register: bubble, hold, held word, fresh word or bubble, in that priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_pc    <= 32'h0;
      IF_ID_inst  <= NOP_INST;
      IF_ID_valid <= 1'b0;
    end else if (redirect || IF_ID_flush) begin
      IF_ID_inst  <= NOP_INST;
      IF_ID_valid <= 1'b0;
    end else if (pc_freeze) begin
      IF_ID_valid <= IF_ID_valid;
    end else if (hold_valid) begin
      IF_ID_pc    <= hold_pc;
      IF_ID_inst  <= hold_inst;
      IF_ID_valid <= 1'b1;
    end else if (rsp_wait) begin
      IF_ID_pc    <= inflight_pc;
      IF_ID_inst  <= imem.imem_rdata;
      IF_ID_valid <= 1'b1;
    end else begin
      IF_ID_inst  <= NOP_INST;
      IF_ID_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Count bubbles loaded into IF/ID and responses thrown away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= 32'h0;
      perf_drop_cnt   <= 32'h0;
    end else begin
      if (bubble_load) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (rsp_drop)    perf_drop_cnt   <= perf_drop_cnt + 32'd1;
    end
  end
`else
  logic unused_ok;
  assign unused_ok = bubble_load ^ rsp_drop;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of per-cycle vectors with
// hand-computed expectations, plus a hand-written asynchronous reset sequence.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] D   = 32'hA000_0000;

  logic clk;
  logic rst_n;
  logic pc_freeze;
  logic IF_ID_flush;
  logic Ex_jump_or_branch;
  logic [31:0] Ex_target_pc;
  logic [31:0] IF_ID_pc;
  logic [31:0] IF_ID_inst;
  logic IF_ID_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_drop_cnt;
`endif

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .pc_freeze         (pc_freeze),
    .IF_ID_flush       (IF_ID_flush),
    .Ex_jump_or_branch (Ex_jump_or_branch),
    .Ex_target_pc      (Ex_target_pc),
    .imem              (imem.master),
    .IF_ID_pc          (IF_ID_pc),
    .IF_ID_inst        (IF_ID_inst),
    .IF_ID_valid       (IF_ID_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_bubble_cnt   (perf_bubble_cnt),
    .perf_drop_cnt     (perf_drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        frz;
    logic        fl;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t v(logic r, logic f, logic fl, logic b, logic [31:0] t,
                             logic rdy, logic rv, logic [31:0] rd,
                             logic eq, logic [31:0] ea, logic [31:0] ep,
                             logic [31:0] ei, logic ev);
    vec_t x;
    x.rst_n = r;  x.frz = f;  x.fl = fl;  x.br = b;  x.tgt = t;
    x.rdy = rdy;  x.rv = rv;  x.rdata = rd;
    x.e_req = eq; x.e_addr = ea; x.e_pc = ep; x.e_inst = ei; x.e_valid = ev;
    return x;
  endfunction

  task automatic checkOutput(input string name, input int idx,
                             input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, check the request side
  // before the rising edge and the IF/ID register just after it.
  task automatic applyStimulus(input vec_t x, input int idx);
    @(negedge clk);
    rst_n                = x.rst_n;
    pc_freeze            = x.frz;
    IF_ID_flush          = x.fl;
    Ex_jump_or_branch    = x.br;
    Ex_target_pc         = x.tgt;
    imem.imem_ready      = x.rdy;
    imem.imem_rvalid     = x.rv;
    imem.imem_rdata      = x.rdata;
    #1;
    checkOutput("imem_req", idx, {31'h0, imem.imem_req}, {31'h0, x.e_req});
    checkOutput("imem_addr", idx, imem.imem_addr, x.e_addr);
    @(posedge clk);
    #1;
    checkOutput("IF_ID_pc", idx, IF_ID_pc, x.e_pc);
    checkOutput("IF_ID_inst", idx, IF_ID_inst, x.e_inst);
    checkOutput("IF_ID_valid", idx, {31'h0, IF_ID_valid}, {31'h0, x.e_valid});
  endtask

  initial begin
    rst_n = 1'b0;
    pc_freeze = 1'b0;
    IF_ID_flush = 1'b0;
    Ex_jump_or_branch = 1'b0;
    Ex_target_pc = 32'h0;
    imem.imem_ready = 1'b1;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata = 32'h0;

    // Streaming with a 1-cycle memory: IF/ID shows 0,4,8,12 back to back.
    vecs.push_back(v(1,0,0,0,0,1,0,0,             1,32'h0,   32'h0,  NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h0,       1,32'h4,   32'h0,  D+32'h0,  1));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h4,       1,32'h8,   32'h4,  D+32'h4,  1));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h8,       1,32'hC,   32'h8,  D+32'h8,  1));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'hC,       1,32'h10,  32'hC,  D+32'hC,  1));
    // Reset while WAIT, then a late rvalid from the old request is ignored.
    vecs.push_back(v(0,0,0,0,0,1,0,0,             1,32'h0,   32'h0,  NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h10,      1,32'h0,   32'h0,  NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h0,       1,32'h4,   32'h0,  D+32'h0,  1));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h4,       1,32'h8,   32'h4,  D+32'h4,  1));
    // Freeze for 3 cycles while the pc=8 word arrives; delivered on unfreeze.
    vecs.push_back(v(1,1,0,0,0,1,1,D+32'h8,       0,32'hC,   32'h4,  D+32'h4,  1));
    vecs.push_back(v(1,1,0,0,0,1,0,0,             0,32'hC,   32'h4,  D+32'h4,  1));
    vecs.push_back(v(1,1,0,0,0,1,0,0,             0,32'hC,   32'h4,  D+32'h4,  1));
    vecs.push_back(v(1,0,0,0,0,1,0,0,             1,32'hC,   32'h8,  D+32'h8,  1));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'hC,       1,32'h10,  32'hC,  D+32'hC,  1));
    // Redirect to 0x100 while the 0x10 request is outstanding: DROP the stale word.
    vecs.push_back(v(1,0,0,0,0,1,0,0,             0,32'h14,  32'hC,  NOP,      0));
    vecs.push_back(v(1,0,0,1,32'h100,1,0,0,       0,32'h14,  32'hC,  NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,0,0,             0,32'h100, 32'hC,  NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h10,      0,32'h100, 32'hC,  NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,0,0,             1,32'h100, 32'hC,  NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h100,     1,32'h104, 32'h100,D+32'h100,1));
    // Redirect coincident with rvalid: response discarded, refetch 0x100.
    vecs.push_back(v(1,0,0,1,32'h100,1,1,D+32'h104,0,32'h108,32'h100,NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,0,0,             1,32'h100, 32'h100,NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h100,     1,32'h104, 32'h100,D+32'h100,1));
    // Freeze together with flush: bubble, IF/ID pc kept, fetch resumes at 0x108.
    vecs.push_back(v(1,1,1,0,0,1,0,0,             0,32'h108, 32'h100,NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h104,     1,32'h108, 32'h104,D+32'h104,1));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h108,     1,32'h10C, 32'h108,D+32'h108,1));
    // Memory not ready on the response cycle: word taken, request retried.
    vecs.push_back(v(1,0,0,0,0,0,1,D+32'h10C,     1,32'h110, 32'h10C,D+32'h10C,1));
    vecs.push_back(v(1,0,0,0,0,1,0,0,             1,32'h110, 32'h10C,NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h110,     1,32'h114, 32'h110,D+32'h110,1));
    // Redirect to the top word: PC wraps from FFFF_FFFC to 0.
    vecs.push_back(v(1,0,0,1,32'hFFFF_FFFC,1,0,0, 0,32'h118, 32'h110,NOP,      0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h114,     0,32'hFFFF_FFFC,32'h110,NOP, 0));
    vecs.push_back(v(1,0,0,0,0,1,0,0,             1,32'hFFFF_FFFC,32'h110,NOP, 0));
    vecs.push_back(v(1,0,0,0,0,1,1,32'h1234_5678, 1,32'h0,   32'hFFFF_FFFC,32'h1234_5678,1));
    // Flush alone on a response cycle: bubble, but the next request still issues.
    vecs.push_back(v(1,0,1,0,0,1,1,D+32'h0,       1,32'h4,   32'hFFFF_FFFC,NOP,0));
    vecs.push_back(v(1,0,0,0,0,1,1,D+32'h4,       1,32'h8,   32'h4,  D+32'h4,  1));

    // Hold reset over two edges and check the reset values.
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset IF_ID_valid", -1, {31'h0, IF_ID_valid}, 32'h0);
    checkOutput("reset IF_ID_inst", -1, IF_ID_inst, NOP);
    checkOutput("reset IF_ID_pc", -1, IF_ID_pc, 32'h0);
    checkOutput("reset imem_addr", -1, imem.imem_addr, 32'h0);

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    // Asynchronous reset mid-cycle while WAIT: outputs drop at once.
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async IF_ID_valid", 100, {31'h0, IF_ID_valid}, 32'h0);
    checkOutput("async IF_ID_inst", 100, IF_ID_inst, NOP);
    checkOutput("async IF_ID_pc", 100, IF_ID_pc, 32'h0);
    checkOutput("async imem_addr", 100, imem.imem_addr, 32'h0);
    applyStimulus(v(1,0,0,0,0,1,1,32'hDEAD_BEEF, 1,32'h0, 32'h0, NOP,     0), 101);
    applyStimulus(v(1,0,0,0,0,1,1,D+32'h0,       1,32'h4, 32'h0, D+32'h0, 1), 102);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the hazard detect unit.
- Owns the PC and the IF/ID pipeline register.
- Drives a single-outstanding-request instruction-memory handshake.
- Consumes the hazard unit's pc_freeze and IF_ID_flush, plus the EX-stage redirect (Ex_jump_or_branch with target), and feeds ID with pc, instruction and a valid flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word placed in IF/ID for a bubble (addi x0,x0,0).

Ports:
- clk  input  1  clock; all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- pc_freeze  input  1  stall fetch: hold PC and IF/ID, issue no request
- IF_ID_flush  input  1  load bubble into IF/ID this edge
- Ex_jump_or_branch  input  1  redirect taken in EX
- Ex_target_pc  input  32  redirect target
- imem_req  output  1  fetch request (combinational)
- imem_addr  output  32  fetch address, equals pc register
- imem_ready  input  1  memory accepts request when imem_req && imem_ready
- imem_rvalid  input  1  response valid, earliest one cycle after accept
- imem_rdata  input  32  response instruction
- IF_ID_pc  output  32  PC of instruction in ID
- IF_ID_inst  output  32  instruction in ID
- IF_ID_valid  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC, state=ISSUE, hold_valid=0.
  - IF_ID_valid=0, IF_ID_inst=NOP_INST, IF_ID_pc=0.
- pc register is the next address to fetch.
- On accept:
  - pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - inflight_pc<=pc.
  - state<=WAIT.
- States:
  - ISSUE: no request outstanding.
  - WAIT: one request outstanding, data wanted.
  - DROP: one request outstanding, data stale.
- imem_req = !pc_freeze && !Ex_jump_or_branch && (state==ISSUE || (state==WAIT && imem_rvalid)).
  - Back-to-back issue on the response cycle gives 1 instr/cycle with zero-wait memory.
- Response in WAIT, not frozen, no redirect: instruction goes to IF/ID. State goes to WAIT if a new request is accepted, else ISSUE.
- Response in WAIT while pc_freeze=1 and no redirect:
  - Capture into hold buffer (hold_inst, hold_pc, hold_valid=1); state<=ISSUE.
  - Delivered to IF/ID on the first non-frozen, non-redirect cycle, with a new request issued in that same cycle.
- Redirect (Ex_jump_or_branch=1), highest priority, any state:
  - pc<=Ex_target_pc; hold_valid<=0; IF/ID<=bubble (even if pc_freeze).
  - WAIT without rvalid -> DROP.
  - WAIT with rvalid -> ISSUE, data discarded.
  - DROP stays DROP.
- DROP: on imem_rvalid, data discarded, state<=ISSUE, no request that cycle.
- IF/ID update each edge, first match wins:
  1. redirect or IF_ID_flush -> bubble (valid=0, inst=NOP_INST, pc unchanged).
  2. pc_freeze -> hold.
  3. hold_valid -> hold contents, then hold_valid<=0.
  4. state==WAIT && imem_rvalid -> {inflight_pc, imem_rdata, valid=1}.
  5. otherwise -> bubble.
- pc_freeze && IF_ID_flush, no redirect: IF/ID bubble; pc, state and hold buffer retained.
- imem_rvalid outside WAIT/DROP is ignored.
- Memory must not return rvalid in the accept cycle.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_bubble_cnt[31:0] and perf_drop_cnt[31:0].
  - perf_bubble_cnt increments on each edge IF/ID is loaded with a bubble.
  - perf_drop_cnt increments on each discarded response (DROP response, or WAIT response coincident with redirect).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset, imem_ready=1, 1-cycle memory returning addr-tagged data -> IF_ID_pc 0,4,8,12 on consecutive cycles after the first response, IF_ID_valid=1, no bubbles.
- pc_freeze held 3 cycles while response for pc=8 arrives -> IF/ID holds pc=4 instruction; pc=8 word delivered on the first unfrozen cycle; imem_req=0 during freeze.
- Redirect to 32'h100 while request for pc=0x10 outstanding (rvalid delayed 3 cycles) -> DROP; stale response discarded; next imem_addr=0x100; IF/ID bubbles until the 0x100 word arrives.
- Redirect coincident with rvalid -> response discarded, state ISSUE, next fetch 0x100, IF_ID_valid=0.
- pc_freeze=1 with IF_ID_flush=1 for one cycle -> IF_ID_valid=0, inst=32'h13, pc unchanged, fetch resumes at the same address.
- rst_n asserted mid-WAIT -> outputs immediately at reset values; after release, first imem_addr=RESET_PC; a late rvalid from the old request is ignored.
